decode_stage: RTL and testbench
===============================

// Module: decode_stage
// PURPOSE
//  RV64I decode stage sitting directly upstream of RegisterFile. Accepts fetched
//  instructions over valid/ready, drives RegisterFile rs1/rs2, and captures its
//  1-cycle synchronous read data. Presents decoded fields, the sign-extended
//  immediate and operand values to execute.
//  Covers the register file's write/read collision (old data returned) by snooping
//  writeback, and forces x0 to zero.
// PARAMETERS
//  XLEN       64             datapath width
//  NOP_INSTR  32'h00000013   held instruction after reset/flush (addi x0,x0,0)
// PORTS
//  clk          in   1     clock; all state on posedge
//  rst_n        in   1     asynchronous active-low reset
//  flush        in   1     kill held/incoming instruction (branch redirect)
//  in_valid     in   1     fetch has instruction
//  in_ready     out  1     stage can accept this cycle
//  in_instr     in   32    instruction word
//  in_pc        in   XLEN  instruction PC
//  rf_rs1       out  5     to RegisterFile rs1
//  rf_rs2       out  5     to RegisterFile rs2
//  rf_data1     in   XLEN  from RegisterFile data1 (valid 1 cycle after rf_rs1)
//  rf_data2     in   XLEN  from RegisterFile data2
//  wb_we        in   1     snoop of RegisterFile we
//  wb_rd        in   5     snoop of RegisterFile rd
//  wb_data      in   XLEN  snoop of RegisterFile write_data
//  out_valid    out  1     decoded instruction available
//  out_ready    in   1     execute accepts
//  out_pc       out  XLEN  PC of held instruction
//  out_instr    out  32    held instruction word
//  out_rd       out  5     destination register
//  out_rs1_val  out  XLEN  operand 1 (0 when rs1==x0)
//  out_rs2_val  out  XLEN  operand 2 (0 when rs2==x0)
//  out_imm      out  XLEN  sign-extended immediate per format
//  out_illegal  out  1     opcode not in RV64I set
// BEHAVIOUR
//  - Reset (async, rst_n=0): out_valid=0; held instr=NOP_INSTR; out_pc=0;
//    out_imm=0; out_illegal=0; bypass flags=0. Outputs valid from first edge after release.
//  - FSM: EMPTY (out_valid=0) / FULL (out_valid=1).
//  - in_ready = !flush && (!out_valid || out_ready); accept = in_valid && in_ready.
//  - Transitions: EMPTY -accept-> FULL. FULL -out_ready & !accept-> EMPTY.
//    FULL -out_ready & accept-> FULL (back-to-back, no bubble). FULL -!out_ready-> FULL, held.
//  - flush: next edge -> EMPTY, held instr=NOP_INSTR, no accept that cycle; overrides all.
//  - rf_rs1/rf_rs2 = accept ? in_instr[19:15]/[24:20] : held instr fields (combinational).
//    Every cycle re-reads, so stalled operands track later writebacks.
//  - Latency: accept at edge t -> out_valid, operands, fields valid after edge t (1 cycle).
//  - Bypass (per operand): at each edge, byp <= wb_we && wb_rd==rf_rsN && rf_rsN!=0;
//    byp_data <= wb_data. out_rsN_val = (rsN==0) ? 0 : byp ? byp_data : rf_dataN.
//  - Immediate (registered on accept): I, S, B (bit0=0), U (<<12), J (bit0=0).
//    Sign-extend from instr[31] to XLEN. Other formats (R) -> 0.
//  - out_illegal on accept if opcode[6:0] not in {LUI,AUIPC,JAL,JALR,BRANCH,LOAD,STORE,
//    OP-IMM,OP,OP-IMM-32,OP-32,MISC-MEM,SYSTEM} or instr[1:0]!=2'b11.
//  - Illegal instructions still flow (out_valid=1); execute traps.
//  - Fields/out_pc/out_imm stable while out_valid && !out_ready.
// STRUCTURE
//  - riscv_pkg: opcode localparams, imm-format enum, NOP constant, XLEN default.
//  - Sub-module imm_gen (combinational instr -> imm, format); FSM/bypass in decode_stage.
// TESTING
//  - Reset mid-stream: rst_n=0 while FULL -> out_valid=0 immediately, in_ready=1, rf_rs1=0.
//  - RF x2=7, accept 0xFFB10093 (addi x1,x2,-5) -> next cycle out_valid=1,
//    out_rs1_val=7, out_rd=1, out_imm=64'hFFFF_FFFF_FFFF_FFFB.
//  - Collision: accept rs1=x3 same cycle wb_we=1,wb_rd=3,wb_data=0x55 -> out_rs1_val=0x55.
//  - Stall: out_ready=0 4 cycles, wb writes x3=0xAA in cycle 2 -> out_rs1_val=0xAA
//    from cycle 3; out_instr/out_imm unchanged; in_ready=0 throughout.
//  - x0: instr rs1=x0, wb_we=1 wb_rd=0 wb_data=0x1234 -> out_rs1_val=0.
//  - flush=1 with in_valid=1 while FULL -> in_ready=0; next cycle out_valid=0.
//    No accept; out_instr=0x00000013.

Source files
------------

// File: rtl/decode_stage_pkg.sv
// Shared RV64I decode constants: opcodes, immediate formats, NOP word.
package decode_stage_pkg;

    localparam int          XLEN_DEF      = 64;
    localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;  // addi x0,x0,0

    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

    typedef enum logic [2:0] {
        FMT_R,
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_U,
        FMT_J
    } imm_fmt_t;

    // All legal RV64I major opcodes end in 2'b11, so a full 7-bit match
    // also rejects compressed encodings.
    function automatic logic opcode_legal(input logic [6:0] opc);
        case (opc)
            OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD,
            OPC_STORE, OPC_OP_IMM, OPC_OP, OPC_OP_IMM_32, OPC_OP_32,
            OPC_MISC_MEM, OPC_SYSTEM: opcode_legal = 1'b1;
            default:                  opcode_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Fetch-to-decode and decode-to-execute handshake bundle.
interface decode_stage_if #(
    parameter int XLEN = 64
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [XLEN-1:0] in_pc;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [31:0]     out_instr;
    logic [4:0]      out_rd;
    logic [XLEN-1:0] out_rs1_val;
    logic [XLEN-1:0] out_rs2_val;
    logic [XLEN-1:0] out_imm;
    logic            out_illegal;

    // Environment side: fetch drives instructions, execute drives out_ready.
    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, out_instr, out_rd,
               out_rs1_val, out_rs2_val, out_imm, out_illegal
    );

    // Decode stage side.
    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_pc, out_instr, out_rd,
               out_rs1_val, out_rs2_val, out_imm, out_illegal
    );
endinterface

// File: rtl/decode_stage_imm_gen.sv
// Combinational immediate extraction: picks the format from the opcode and
// sign-extends from instr[31] to XLEN. R-type and unknown opcodes give 0.
module decode_stage_imm_gen
    import decode_stage_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic                   [31:0] instr,
    output logic signed [XLEN-1:0]        imm
);
    imm_fmt_t           fmt;
    logic signed [31:0] imm32;

    // Format select; SYSTEM and MISC-MEM share the I-type layout.
    always_comb begin
        fmt = FMT_R;
        case (instr[6:0])
            OPC_OP_IMM, OPC_OP_IMM_32, OPC_LOAD, OPC_JALR,
            OPC_MISC_MEM, OPC_SYSTEM: fmt = FMT_I;
            OPC_STORE:                fmt = FMT_S;
            OPC_BRANCH:               fmt = FMT_B;
            OPC_LUI, OPC_AUIPC:       fmt = FMT_U;
            OPC_JAL:                  fmt = FMT_J;
            default:                  fmt = FMT_R;
        endcase
    end

    // Assemble the 32-bit immediate, then sign-extend to XLEN.
    always_comb begin
        imm32 = '0;
        case (fmt)
            FMT_I: imm32 = {{20{instr[31]}}, instr[31:20]};
            FMT_S: imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            FMT_B: imm32 = {{19{instr[31]}}, instr[31], instr[7],
                            instr[30:25], instr[11:8], 1'b0};
            FMT_U: imm32 = {instr[31:12], 12'h000};
            FMT_J: imm32 = {{11{instr[31]}}, instr[31], instr[19:12],
                            instr[20], instr[30:21], 1'b0};
            default: imm32 = '0;
        endcase
        imm = {{(XLEN-32){imm32[31]}}, imm32};
    end
endmodule

// File: rtl/decode_stage.sv
// RV64I decode stage in front of a 1-cycle synchronous-read register file.
// Holds one instruction, re-reads its operands every cycle and patches the
// register file's write/read collision with a one-entry writeback snoop.
module decode_stage
    import decode_stage_pkg::*;
#(
    parameter int          XLEN      = XLEN_DEF,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    decode_stage_if.slave   bus,
    output logic [4:0]      rf_rs1,
    output logic [4:0]      rf_rs2,
    input  logic [XLEN-1:0] rf_data1,
    input  logic [XLEN-1:0] rf_data2,
    input  logic            wb_we,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data
);
    typedef enum logic {EMPTY, FULL} state_t;

    state_t                 state_p1, state_nx;
    logic                   in_ready_c;
    logic                   accept;
    logic signed [XLEN-1:0] imm_p0;

    logic [31:0]            instr_p1;
    logic [XLEN-1:0]        pc_p1;
    logic signed [XLEN-1:0] imm_p1;
    logic                   illegal_p1;
    logic                   byp1_p1, byp2_p1;
    logic [XLEN-1:0]        byp_data1_p1, byp_data2_p1;
    logic                   vld_p1;

    decode_stage_imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .instr (bus.in_instr),
        .imm   (imm_p0)
    );

    // Handshake and next-state: flush wins, otherwise accept refills and a
    // consumed entry without a replacement drains.
    always_comb begin
        in_ready_c = !flush && (state_p1 == EMPTY || bus.out_ready);
        accept     = bus.in_valid && in_ready_c;
        state_nx   = state_p1;
        if (flush)
            state_nx = EMPTY;
        else if (accept)
            state_nx = FULL;
        else if (state_p1 == FULL && bus.out_ready)
            state_nx = EMPTY;
    end

    // Occupancy state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_p1 <= EMPTY;
        else        state_p1 <= state_nx;
    end

    // Capture instruction, PC, immediate and legality on accept; a flush
    // parks a NOP so the register-file address lines go quiet.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_p1   <= NOP_INSTR;
            pc_p1      <= '0;
            imm_p1     <= '0;
            illegal_p1 <= 1'b0;
        end else if (flush) begin
            instr_p1   <= NOP_INSTR;
            imm_p1     <= '0;
            illegal_p1 <= 1'b0;
        end else if (accept) begin
            instr_p1   <= bus.in_instr;
            pc_p1      <= bus.in_pc;
            imm_p1     <= imm_p0;
            illegal_p1 <= !opcode_legal(bus.in_instr[6:0]);
        end
    end

    // Address the register file with the incoming instruction on accept,
    // otherwise keep re-reading the held one so stalls see new writebacks.
    assign rf_rs1 = accept ? bus.in_instr[19:15] : instr_p1[19:15];
    assign rf_rs2 = accept ? bus.in_instr[24:20] : instr_p1[24:20];

    // Collision flags: a write landing on the register being read this edge
    // returns old data from the file, so remember to use the snooped value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byp1_p1 <= 1'b0;
            byp2_p1 <= 1'b0;
        end else begin
            byp1_p1 <= wb_we && (wb_rd == rf_rs1) && (rf_rs1 != 5'd0);
            byp2_p1 <= wb_we && (wb_rd == rf_rs2) && (rf_rs2 != 5'd0);
        end
    end

    // Snooped writeback data; only consulted when its flag is set.
    always_ff @(posedge clk) begin
        byp_data1_p1 <= wb_data;
        byp_data2_p1 <= wb_data;
    end

    // ---- stage p1 outputs ----
    assign vld_p1          = (state_p1 == FULL);
    assign bus.in_ready    = in_ready_c;
    assign bus.out_valid   = vld_p1;
    assign bus.out_pc      = pc_p1;
    assign bus.out_instr   = instr_p1;
    assign bus.out_rd      = instr_p1[11:7];
    assign bus.out_imm     = imm_p1;
    assign bus.out_illegal = illegal_p1;
    assign bus.out_rs1_val = (instr_p1[19:15] == 5'd0) ? '0 :
                             (byp1_p1 ? byp_data1_p1 : rf_data1);
    assign bus.out_rs2_val = (instr_p1[24:20] == 5'd0) ? '0 :
                             (byp2_p1 ? byp_data2_p1 : rf_data2);
endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: register-file model, directed scenarios, random
// traffic, scoreboard queue checked by an independent negedge monitor.
module tb_decode_stage;
    import decode_stage_pkg::*;

    localparam int XLEN = 64;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            flush = 1'b0;
    logic [4:0]      rf_rs1, rf_rs2;
    logic [XLEN-1:0] rf_data1, rf_data2;
    logic            wb_we = 1'b0;
    logic [4:0]      wb_rd = '0;
    logic [XLEN-1:0] wb_data = '0;

    always #5 clk = ~clk;

    decode_stage_if #(.XLEN(XLEN)) bus ();

    decode_stage #(.XLEN(XLEN), .NOP_INSTR(32'h0000_0013)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .bus      (bus.slave),
        .rf_rs1   (rf_rs1),
        .rf_rs2   (rf_rs2),
        .rf_data1 (rf_data1),
        .rf_data2 (rf_data2),
        .wb_we    (wb_we),
        .wb_rd    (wb_rd),
        .wb_data  (wb_data)
    );

    // Register file: synchronous read returning pre-write data on collision.
    logic [XLEN-1:0] regs [32];
    always @(posedge clk) begin
        rf_data1 <= regs[rf_rs1];
        rf_data2 <= regs[rf_rs2];
        if (wb_we) regs[wb_rd] <= wb_data;
    end

    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
        logic [63:0] imm;
        logic        ill;
    } item_t;

    item_t sbq [$];
    int    n_tests = 0;
    int    n_fail  = 0;
    bit    full      = 1'b0;   // reference occupancy for the current cycle
    bit    exp_ready = 1'b1;
    bit    mon_en    = 1'b0;
    bit    nop_chk   = 1'b0;

    function automatic logic ref_legal(input logic [31:0] i);
        return i[6:0] inside {7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23,
                              7'h13, 7'h33, 7'h1B, 7'h3B, 7'h0F, 7'h73};
    endfunction

    function automatic logic [63:0] ref_imm(input logic [31:0] i);
        logic signed [11:0] s12;
        logic signed [12:0] s13;
        logic signed [20:0] s21;
        logic signed [31:0] s32;
        longint             v;
        v = 0;
        case (i[6:0])
            7'h13, 7'h1B, 7'h03, 7'h67, 7'h0F, 7'h73: begin
                s12 = i[31:20]; v = longint'(s12);
            end
            7'h23: begin s12 = {i[31:25], i[11:7]}; v = longint'(s12); end
            7'h63: begin s13 = {i[31], i[7], i[30:25], i[11:8], 1'b0}; v = longint'(s13); end
            7'h37, 7'h17: begin s32 = {i[31:12], 12'h000}; v = longint'(s32); end
            7'h6F: begin s21 = {i[31], i[19:12], i[20], i[30:21], 1'b0}; v = longint'(s21); end
            default: v = 0;
        endcase
        return 64'(v);
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // One cycle of stimulus; issued at posedge+1, returns at next posedge+1.
    task automatic drive(input bit vld, input logic [31:0] ins, input logic [63:0] pc,
                         input bit ordy, input bit we, input logic [4:0] rd,
                         input logic [63:0] d, input bit fl);
        bit acc, nfull;
        item_t it;
        bus.in_valid  = vld;
        bus.in_instr  = ins;
        bus.in_pc     = pc;
        bus.out_ready = ordy;
        wb_we = we; wb_rd = rd; wb_data = d; flush = fl;
        exp_ready = !fl && (!full || ordy);
        acc = vld && exp_ready;
        if (acc) begin
            it.pc = pc; it.instr = ins; it.imm = ref_imm(ins); it.ill = !ref_legal(ins);
            sbq.push_back(it);
        end
        nfull = fl ? 1'b0 : acc ? 1'b1 : (full && ordy) ? 1'b0 : full;
        @(posedge clk);
        #1;
        full = nfull;
    endtask

    task automatic idle(input bit ordy);
        drive(1'b0, 32'h0, 64'h0, ordy, 1'b0, 5'd0, 64'h0, 1'b0);
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
        check({tag, "_in_ready"},  64'(bus.in_ready), 64'd1);
        check({tag, "_rf_rs1"},    64'(rf_rs1), 64'd0);
        check({tag, "_out_instr"}, 64'(bus.out_instr), 64'h13);
        check({tag, "_out_pc"},    bus.out_pc, 64'd0);
        check({tag, "_out_imm"},   bus.out_imm, 64'd0);
        check({tag, "_illegal"},   64'(bus.out_illegal), 64'd0);
    endtask

    // Monitor: compares the held entry against the scoreboard head each cycle
    // it is presented; operands must equal the architectural register value.
    always @(negedge clk) begin
        if (mon_en) begin
            check("in_ready", 64'(bus.in_ready), 64'(exp_ready));
            check("out_valid", 64'(bus.out_valid), 64'(full));
            if (nop_chk) check("flush_nop_instr", 64'(bus.out_instr), 64'h13);
            nop_chk = flush;
            if (full) begin
                if (sbq.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL sb_empty: entry presented with nothing expected at %0t", $time);
                end else begin
                    item_t it;
                    logic [4:0] r1, r2;
                    it = sbq[0];
                    r1 = it.instr[19:15];
                    r2 = it.instr[24:20];
                    check("out_pc", bus.out_pc, it.pc);
                    check("out_instr", 64'(bus.out_instr), 64'(it.instr));
                    check("out_rd", 64'(bus.out_rd), 64'(it.instr[11:7]));
                    check("out_imm", bus.out_imm, it.imm);
                    check("out_illegal", 64'(bus.out_illegal), 64'(it.ill));
                    check("out_rs1_val", bus.out_rs1_val, (r1 == 5'd0) ? 64'd0 : regs[r1]);
                    check("out_rs2_val", bus.out_rs2_val, (r2 == 5'd0) ? 64'd0 : regs[r2]);
                    if (bus.out_ready || flush) void'(sbq.pop_front());
                end
            end
        end
    end

    logic [6:0] opc_tab [16];

    initial begin
        opc_tab = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13,
                    7'h33, 7'h1B, 7'h3B, 7'h0F, 7'h73, 7'h0B, 7'h07, 7'h7F};
        bus.in_valid = 1'b0; bus.in_instr = '0; bus.in_pc = '0; bus.out_ready = 1'b0;

        // Power-on reset.
        #12;
        reset_checks("por");
        @(posedge clk); #1;
        rst_n = 1'b1;
        full = 1'b0;
        exp_ready = 1'b1;
        mon_en = 1'b1;

        // Fill the register file with known random data.
        for (int i = 0; i < 32; i++)
            drive(1'b0, 32'h0, 64'h0, 1'b1, 1'b1, 5'(i), {$urandom, $urandom}, 1'b0);

        // addi x1,x2,-5 with x2 = 7.
        drive(1'b0, 32'h0, 64'h0, 1'b1, 1'b1, 5'd2, 64'd7, 1'b0);
        drive(1'b1, 32'hFFB1_0093, 64'h1000, 1'b1, 1'b0, 5'd0, 64'h0, 1'b0);
        idle(1'b1);

        // Write to x3 on the accept edge of addi x5,x3,1.
        drive(1'b1, 32'h0011_8293, 64'h1004, 1'b1, 1'b1, 5'd3, 64'h55, 1'b0);
        // Hold it four cycles, x3 rewritten in the second; fetch keeps offering.
        drive(1'b1, 32'h0011_8313, 64'h1008, 1'b0, 1'b0, 5'd0, 64'h0, 1'b0);
        drive(1'b1, 32'h0011_8313, 64'h1008, 1'b0, 1'b1, 5'd3, 64'hAA, 1'b0);
        drive(1'b1, 32'h0011_8313, 64'h1008, 1'b0, 1'b0, 5'd0, 64'h0, 1'b0);
        drive(1'b1, 32'h0011_8313, 64'h1008, 1'b0, 1'b0, 5'd0, 64'h0, 1'b0);
        idle(1'b1);
        idle(1'b1);

        // rs1 = x0 while writing x0.
        drive(1'b1, 32'h0050_0093, 64'h2000, 1'b0, 1'b1, 5'd0, 64'h1234, 1'b0);
        idle(1'b1);

        // Flush while holding, with fetch offering a new instruction.
        drive(1'b1, 32'h0010_0113, 64'h3000, 1'b0, 1'b0, 5'd0, 64'h0, 1'b0);
        drive(1'b1, 32'h0020_0193, 64'h3004, 1'b0, 1'b0, 5'd0, 64'h0, 1'b1);
        idle(1'b0);
        idle(1'b1);

        // Random traffic.
        for (int c = 0; c < 3000; c++) begin
            logic [31:0] r, ins;
            logic [6:0]  op;
            r  = $urandom;
            op = opc_tab[$urandom_range(0, 15)];
            if (op == 7'h7F) op = 7'($urandom);
            ins = {r[31:7], op};
            if ($urandom_range(0, 1) == 1) ins[19:15] = 5'($urandom_range(0, 7));
            if ($urandom_range(0, 1) == 1) ins[24:20] = 5'($urandom_range(0, 7));
            drive($urandom_range(0, 9) < 7, ins, {$urandom, $urandom},
                  $urandom_range(0, 9) < 6, $urandom_range(0, 1) == 1,
                  5'($urandom_range(0, 7)), {$urandom, $urandom},
                  $urandom_range(0, 19) == 0);
        end

        // Reset while holding an instruction.
        drive(1'b1, 32'hFFB1_0093, 64'h4000, 1'b0, 1'b0, 5'd0, 64'h0, 1'b0);
        mon_en = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        flush = 1'b0;
        wb_we = 1'b0;
        rst_n = 1'b0;
        #1;
        reset_checks("midrst");
        sbq.delete();
        full = 1'b0;
        exp_ready = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        mon_en = 1'b1;

        // Traffic after reset, then drain.
        for (int c = 0; c < 300; c++)
            drive($urandom_range(0, 1) == 1, {$urandom_range(0, 32'h01FF_FFFF), 7'h13},
                  {$urandom, $urandom}, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)),
                  {$urandom, $urandom}, 1'b0);
        for (int c = 0; c < 4; c++) idle(1'b1);
        mon_en = 1'b0;
        check("sb_drained", 64'(sbq.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
